// File: rtl/rgmii_tx_fmt.sv
// RGMII transmit formatter: wraps MAC bytes with preamble/SFD, pads short frames,
// enforces the inter-frame gap and registers the DDR nibble pairs for TXD/TX_CTL.
module rgmii_tx_fmt #(
    parameter int PREAMBLE_LEN = 7,
    parameter int IFG_LEN      = 12,
    parameter int PAD_EN       = 1,
    parameter int MIN_LEN      = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       s_valid,
    input  logic [7:0] s_data,
    input  logic       s_last,
    output logic       s_ready,
    output logic [3:0] txd_d0,
    output logic [3:0] txd_d1,
    output logic       txctl_d0,
    output logic       txctl_d1,
    output logic       busy,
    output logic       frame_done,
    output logic       underrun
);
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PRE  = 3'd1;
    localparam logic [2:0] ST_SFD  = 3'd2;
    localparam logic [2:0] ST_DATA = 3'd3;
    localparam logic [2:0] ST_PAD  = 3'd4;
    localparam logic [2:0] ST_DROP = 3'd5;
    localparam logic [2:0] ST_IFG  = 3'd6;

    logic [2:0]  state_reg, state_next;
    logic [15:0] cnt_reg, cnt_next, cnt_sat;
    logic [16:0] cnt_inc;
    logic        pad_final, long_enough;
    logic [7:0]  txd_reg, txd_next;
    logic        ctl0_reg, ctl0_next;
    logic        ctl1_reg, ctl1_next;
    logic        done_reg, done_next;
    logic        urun_reg, urun_next;

    // 17-bit increment so the MIN_LEN comparison still works at the saturation point
    assign cnt_inc     = {1'b0, cnt_reg} + 17'd1;
    assign cnt_sat     = (cnt_reg == 16'hFFFF) ? 16'hFFFF : cnt_inc[15:0];
    assign pad_final   = (cnt_inc >= 17'(MIN_LEN));
    assign long_enough = (PAD_EN == 0) || pad_final;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        txd_next   = 8'h00;
        ctl0_next  = 1'b0;
        ctl1_next  = 1'b0;
        done_next  = 1'b0;
        urun_next  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (s_valid) begin
                    state_next = ST_PRE;
                    cnt_next   = 16'd0;
                end
            end
            ST_PRE: begin
                txd_next  = 8'h55;
                ctl0_next = 1'b1;
                ctl1_next = 1'b1;
                if (cnt_reg == 16'(PREAMBLE_LEN - 1)) begin
                    state_next = ST_SFD;
                    cnt_next   = 16'd0;
                end else begin
                    cnt_next = cnt_inc[15:0];
                end
            end
            ST_SFD: begin
                txd_next   = 8'hD5;
                ctl0_next  = 1'b1;
                ctl1_next  = 1'b1;
                cnt_next   = 16'd0;
                state_next = ST_DATA;
            end
            ST_DATA: begin
                if (s_valid) begin
                    txd_next  = s_data;
                    ctl0_next = 1'b1;
                    ctl1_next = 1'b1;
                    cnt_next  = cnt_sat;
                    if (s_last) begin
                        if (long_enough) begin
                            done_next  = 1'b1;
                            state_next = ST_IFG;
                            cnt_next   = 16'd0;
                        end else begin
                            state_next = ST_PAD;
                        end
                    end
                end else begin
                    // MAC starved us: flag TX_ER for one byte and discard the rest of the frame
                    ctl0_next  = 1'b1;
                    ctl1_next  = 1'b0;
                    urun_next  = 1'b1;
                    state_next = ST_DROP;
                end
            end
            ST_PAD: begin
                ctl0_next = 1'b1;
                ctl1_next = 1'b1;
                cnt_next  = cnt_sat;
                if (pad_final) begin
                    done_next  = 1'b1;
                    state_next = ST_IFG;
                    cnt_next   = 16'd0;
                end
            end
            ST_DROP: begin
                if (s_valid && s_last) begin
                    state_next = ST_IFG;
                    cnt_next   = 16'd0;
                end
            end
            ST_IFG: begin
                if (cnt_reg == 16'(IFG_LEN - 1)) begin
                    state_next = ST_IDLE;
                    cnt_next   = 16'd0;
                end else begin
                    cnt_next = cnt_inc[15:0];
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = 16'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 16'd0;
            txd_reg   <= 8'h00;
            ctl0_reg  <= 1'b0;
            ctl1_reg  <= 1'b0;
            done_reg  <= 1'b0;
            urun_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            txd_reg   <= txd_next;
            ctl0_reg  <= ctl0_next;
            ctl1_reg  <= ctl1_next;
            done_reg  <= done_next;
            urun_reg  <= urun_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_nib
            assign txd_d0[gi] = txd_reg[gi];
            assign txd_d1[gi] = txd_reg[gi + 4];
        end
    endgenerate

    assign txctl_d0   = ctl0_reg;
    assign txctl_d1   = ctl1_reg;
    assign frame_done = done_reg;
    assign underrun   = urun_reg;
    assign busy       = (state_reg != ST_IDLE);
    assign s_ready    = (state_reg == ST_DATA) || (state_reg == ST_DROP);
endmodule

// File: tb/tb_rgmii_tx_fmt.sv
// Bench for rgmii_tx_fmt: a frame-level model builds the expected per-cycle output
// trace, and one compare process checks the DUT against it every cycle.
module tb_rgmii_tx_fmt;
    localparam int PRE  = 7;
    localparam int IFG  = 12;
    localparam int MINL = 60;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       s_valid = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_last = 1'b0;
    logic       s_ready;
    logic [3:0] txd_d0, txd_d1;
    logic       txctl_d0, txctl_d1, busy, frame_done, underrun;

    rgmii_tx_fmt #(
        .PREAMBLE_LEN(PRE),
        .IFG_LEN     (IFG),
        .PAD_EN      (1),
        .MIN_LEN     (MINL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_last    (s_last),
        .s_ready   (s_ready),
        .txd_d0    (txd_d0),
        .txd_d1    (txd_d1),
        .txctl_d0  (txctl_d0),
        .txctl_d1  (txctl_d1),
        .busy      (busy),
        .frame_done(frame_done),
        .underrun  (underrun)
    );

    always #4 clk = ~clk;

    // One expected output cycle; rdy/bsy describe the state that decided this byte.
    typedef struct {
        logic [7:0] b;
        bit en, er, done, urun, rdy, bsy;
    } rec_t;

    rec_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 1'b0;
    int   en_cnt, done_cnt, urun_cnt, low_run, last_gap;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [7:0] byte_of(input int seed, input int i);
        int v;
        v = seed + i;
        return v[7:0];
    endfunction

    task automatic push(input logic [7:0] b, input bit en, input bit er, input bit done,
                        input bit urun, input bit rdy, input bit bsy);
        rec_t r;
        r.b = b; r.en = en; r.er = er; r.done = done;
        r.urun = urun; r.rdy = rdy; r.bsy = bsy;
        exp_q.push_back(r);
    endtask

    // Frame-level model: what the wire must show for one frame, starting from IDLE
    // with the first byte already offered and the source never stalling except at stall_at.
    task automatic model_frame(input int len, input int seed, input int stall_at);
        int nbytes;
        push(8'h00, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < PRE; i++) push(8'h55, 1, 0, 0, 0, 0, 1);
        push(8'hD5, 1, 0, 0, 0, 0, 1);
        if (stall_at >= 0) begin
            for (int i = 0; i < stall_at; i++) push(byte_of(seed, i), 1, 0, 0, 0, 1, 1);
            push(8'h00, 1, 1, 0, 1, 1, 1);
            for (int i = stall_at; i < len; i++) push(8'h00, 0, 0, 0, 0, 1, 1);
        end else begin
            nbytes = (len < MINL) ? MINL : len;
            for (int i = 0; i < nbytes; i++)
                push((i < len) ? byte_of(seed, i) : 8'h00, 1, 0, (i == nbytes - 1), 0, (i < len), 1);
        end
        for (int i = 0; i < IFG; i++) push(8'h00, 0, 0, 0, 0, 0, 1);
    endtask

    // Source side: offers bytes in order and advances on each handshake.
    task automatic send_frame(input int len, input int seed, input int stall_at);
        int idx;
        int guard;
        bit fire;
        bit stalled;
        idx = 0; guard = 0; stalled = 1'b0;
        while (idx < len) begin
            s_valid = !(idx == stall_at && !stalled);
            s_data  = byte_of(seed, idx);
            s_last  = (idx == len - 1);
            fire    = s_valid && s_ready;
            if (!s_valid) stalled = 1'b1;
            @(negedge clk);
            if (fire) idx++;
            guard++;
            if (guard > 2000) begin
                chk("send_timeout", idx, len);
                break;
            end
        end
    endtask

    task automatic drain();
        s_valid = 1'b0;
        s_last  = 1'b0;
        for (int t = 0; t < 400 && exp_q.size() != 0; t++) @(negedge clk);
        chk("drain_left", exp_q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic start_scenario();
        en_cnt = 0; done_cnt = 0; urun_cnt = 0; low_run = 0; last_gap = 0;
        chk_en = 1'b1;
    endtask

    // Per-cycle compare, sampled 1 ns after the rising edge.
    initial begin
        rec_t e;
        bit nrdy, nbsy;
        forever begin
            @(posedge clk);
            #1;
            if (chk_en) begin
                e.b = 8'h00; e.en = 0; e.er = 0; e.done = 0; e.urun = 0; e.rdy = 0; e.bsy = 0;
                if (exp_q.size() > 0) e = exp_q.pop_front();
                nrdy = 1'b0;
                nbsy = 1'b0;
                if (exp_q.size() > 0) begin
                    nrdy = exp_q[0].rdy;
                    nbsy = exp_q[0].bsy;
                end
                chk("txd", {txd_d1, txd_d0}, e.b);
                chk("txctl_d0", txctl_d0, e.en);
                chk("txctl_d1", txctl_d1, e.en ^ e.er);
                chk("frame_done", frame_done, e.done);
                chk("underrun", underrun, e.urun);
                chk("s_ready", s_ready, nrdy);
                chk("busy", busy, nbsy);
                if (txctl_d0) en_cnt++;
                if (frame_done) done_cnt++;
                if (underrun) urun_cnt++;
                if (!txctl_d0) low_run++;
                else begin
                    if (low_run > 0) last_gap = low_run;
                    low_run = 0;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_en;
        // Reset held with s_valid high: everything quiet.
        s_valid = 1'b1; s_data = 8'h5A; s_last = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_txd", {txd_d1, txd_d0}, 0);
        chk("rst_txctl", {txctl_d1, txctl_d0}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pulses", {frame_done, underrun}, 0);

        // 64-byte frame 0x00..0x3F straight out of reset.
        rst_n = 1'b1;
        model_frame(64, 0, -1);
        chk("model_len", exp_q.size(), 85);
        chk("model_sfd", exp_q[8].b, 8'hD5);
        chk("model_last", exp_q[72].b, 8'h3F);
        chk("model_last_done", exp_q[72].done, 1);
        start_scenario();
        send_frame(64, 0, -1);
        drain();
        chk("f64_en_cycles", en_cnt, 72);
        chk("f64_done_count", done_cnt, 1);
        $display("txn frame64 checks=%0d errors=%0d", checks, errors);

        // 20-byte frame padded to 60.
        model_frame(20, 8'h30, -1);
        n_en = 0;
        foreach (exp_q[i]) if (exp_q[i].en) n_en++;
        chk("model_pad_en", n_en, 68);
        start_scenario();
        send_frame(20, 8'h30, -1);
        drain();
        chk("pad_en_cycles", en_cnt, 68);
        chk("pad_done_count", done_cnt, 1);
        $display("txn pad20 checks=%0d errors=%0d", checks, errors);

        // Underrun after the 10th byte of a 64-byte frame.
        model_frame(64, 8'h40, 10);
        start_scenario();
        send_frame(64, 8'h40, 10);
        drain();
        chk("urun_count", urun_cnt, 1);
        chk("urun_no_done", done_cnt, 0);
        chk("urun_en_cycles", en_cnt, 19);
        $display("txn underrun checks=%0d errors=%0d", checks, errors);

        // Back-to-back 60-byte frames with s_valid held high.
        model_frame(60, 8'h10, -1);
        model_frame(60, 8'h90, -1);
        start_scenario();
        send_frame(60, 8'h10, -1);
        send_frame(60, 8'h90, -1);
        drain();
        chk("b2b_gap", last_gap, 13);
        chk("b2b_done_count", done_cnt, 2);
        $display("txn back2back checks=%0d errors=%0d", checks, errors);

        // 1-byte frame: s_last with the first data byte.
        model_frame(1, 8'hC3, -1);
        start_scenario();
        send_frame(1, 8'hC3, -1);
        drain();
        chk("one_en_cycles", en_cnt, 68);
        $display("txn onebyte checks=%0d errors=%0d", checks, errors);

        // Reset in the 30th DATA cycle: TX_CTL must fall without a clock edge.
        chk_en = 1'b0;
        s_valid = 1'b1; s_data = 8'hA7; s_last = 1'b0;
        repeat (39) @(posedge clk);
        #1;
        chk("mid_pre_txctl", {txctl_d1, txctl_d0}, 2'b11);
        chk("mid_pre_txd", {txd_d1, txd_d0}, 8'hA7);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_async_txctl", {txctl_d1, txctl_d0}, 2'b00);
        chk("mid_async_txd", {txd_d1, txd_d0}, 8'h00);
        chk("mid_async_busy", busy, 0);
        @(negedge clk);
        s_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_post_busy", busy, 0);
        chk("mid_post_ready", s_ready, 0);
        model_frame(5, 8'h80, -1);
        start_scenario();
        send_frame(5, 8'h80, -1);
        drain();
        chk("mid_restart_en", en_cnt, 68);
        $display("txn midreset checks=%0d errors=%0d", checks, errors);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
